// File: rtl/bresenham_line_drawer_if.sv
// Handshake bundle between the plot controller / framebuffer writer and the
// Bresenham line drawer: endpoint request (start/ready) and pixel write port
// (pixel_write/pixel_ready).
interface bresenham_line_drawer_if #(
   parameter int HOR_ACTIVE_PIXELS = 640,
   parameter int VER_ACTIVE_PIXELS = 480
);
   localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS);
   localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS);

   logic [X_WIDTH-1:0] x1;
   logic [Y_WIDTH-1:0] y1;
   logic [X_WIDTH-1:0] x2;
   logic [Y_WIDTH-1:0] y2;
   logic               start;
   logic               ready;
   logic [X_WIDTH-1:0] pixel_x;
   logic [Y_WIDTH-1:0] pixel_y;
   logic               pixel_write;
   logic               pixel_ready;

   // Requester / framebuffer side
   modport master (
      output x1, y1, x2, y2, start, pixel_ready,
      input  ready, pixel_x, pixel_y, pixel_write
   );

   // Line drawer side
   modport slave (
      input  x1, y1, x2, y2, start, pixel_ready,
      output ready, pixel_x, pixel_y, pixel_write
   );
endinterface

// File: rtl/bresenham_line_drawer.sv
// Bresenham line drawer: accepts a segment on start, then emits one pixel per
// cycle (endpoints inclusive) over a valid/ready write port.
// Optional feature macro: LINE_CLIP_EN -- off-screen pixels are stepped over
// silently (pixel_write=0) without changing the line length in cycles.
module bresenham_line_drawer #(
   parameter int HOR_ACTIVE_PIXELS = 640,
   parameter int VER_ACTIVE_PIXELS = 480
) (
   input logic                    clk,
   input logic                    rst_n,
   bresenham_line_drawer_if.slave bus
);
   localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS);
   localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS);
   localparam int W       = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 2;

   typedef enum logic [1:0] {IDLE, INIT, PLOT} state_t;

   state_t             state;
   logic               ready_r;
   logic               pixel_write_r;
   logic [X_WIDTH-1:0] cur_x;
   logic [Y_WIDTH-1:0] cur_y;

   // Latched endpoints and Bresenham terms (data only, no reset needed)
   logic [X_WIDTH-1:0] lx1, lx2;
   logic [Y_WIDTH-1:0] ly1, ly2;
   logic signed [W-1:0] dx, dy, err;
   logic                sx_neg, sy_neg;

   logic signed [W-1:0] dx_init, dy_init, e2, err_nxt;
   logic                step_x, step_y, at_end, advance;
   logic [X_WIDTH-1:0]  nxt_x;
   logic [Y_WIDTH-1:0]  nxt_y;
   logic                init_vis, cur_vis, nxt_vis;

   function automatic logic signed [W-1:0] ext_x(input logic [X_WIDTH-1:0] v);
      return $signed({{(W-X_WIDTH){1'b0}}, v});
   endfunction

   function automatic logic signed [W-1:0] ext_y(input logic [Y_WIDTH-1:0] v);
      return $signed({{(W-Y_WIDTH){1'b0}}, v});
   endfunction

`ifdef LINE_CLIP_EN
   function automatic logic in_frame(input logic [X_WIDTH-1:0] x, input logic [Y_WIDTH-1:0] y);
      return (int'(x) < HOR_ACTIVE_PIXELS) && (int'(y) < VER_ACTIVE_PIXELS);
   endfunction

   assign init_vis = in_frame(lx1, ly1);
   assign cur_vis  = in_frame(cur_x, cur_y);
   assign nxt_vis  = in_frame(nxt_x, nxt_y);
`else
   assign init_vis = 1'b1;
   assign cur_vis  = 1'b1;
   assign nxt_vis  = 1'b1;
`endif

   // Setup terms from the latched endpoints; dy is kept non-positive
   assign dx_init = (lx2 >= lx1) ? (ext_x(lx2) - ext_x(lx1)) : (ext_x(lx1) - ext_x(lx2));
   assign dy_init = (ly2 >= ly1) ? (ext_y(ly1) - ext_y(ly2)) : (ext_y(ly2) - ext_y(ly1));

   // Per-pixel step decision; err stays within [dy, dx] so e2 fits in W bits
   assign e2      = err <<< 1;
   assign step_x  = (e2 >= dy);
   assign step_y  = (e2 <= dx);
   assign err_nxt = err + (step_x ? dy : '0) + (step_y ? dx : '0);
   assign nxt_x   = step_x ? (sx_neg ? cur_x - X_WIDTH'(1) : cur_x + X_WIDTH'(1)) : cur_x;
   assign nxt_y   = step_y ? (sy_neg ? cur_y - Y_WIDTH'(1) : cur_y + Y_WIDTH'(1)) : cur_y;
   assign at_end  = (cur_x == lx2) && (cur_y == ly2);

   // A hidden (clipped) pixel never waits on the framebuffer
   assign advance = (state == PLOT) && (bus.pixel_ready || !cur_vis);

   // Control FSM with registered handshake outputs and current pixel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         ready_r       <= 1'b1;
         pixel_write_r <= 1'b0;
         cur_x         <= '0;
         cur_y         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  ready_r <= 1'b0;
                  state   <= INIT;
               end
            end
            INIT: begin
               cur_x         <= lx1;
               cur_y         <= ly1;
               pixel_write_r <= init_vis;
               state         <= PLOT;
            end
            PLOT: begin
               if (advance) begin
                  if (at_end) begin
                     pixel_write_r <= 1'b0;
                     ready_r       <= 1'b1;
                     state         <= IDLE;
                  end else begin
                     cur_x         <= nxt_x;
                     cur_y         <= nxt_y;
                     pixel_write_r <= nxt_vis;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Endpoint capture, setup terms and error accumulator
   always_ff @(posedge clk) begin
      if ((state == IDLE) && bus.start) begin
         lx1 <= bus.x1;
         ly1 <= bus.y1;
         lx2 <= bus.x2;
         ly2 <= bus.y2;
      end
      if (state == INIT) begin
         dx     <= dx_init;
         dy     <= dy_init;
         sx_neg <= (lx2 < lx1);
         sy_neg <= (ly2 < ly1);
         err    <= dx_init + dy_init;
      end else if (advance && !at_end) begin
         err <= err_nxt;
      end
   end

   assign bus.ready       = ready_r;
   assign bus.pixel_write = pixel_write_r;
   assign bus.pixel_x     = cur_x;
   assign bus.pixel_y     = cur_y;
endmodule

// File: tb/tb_bresenham_line_drawer.sv
// Testbench for bresenham_line_drawer: directed cases plus random lines,
// compared against an integer reference rasteriser kept in the bench.
module tb_bresenham_line_drawer;
   localparam int H = 640;
   localparam int V = 480;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   bresenham_line_drawer_if #(.HOR_ACTIVE_PIXELS(H), .VER_ACTIVE_PIXELS(V)) lif ();

   bresenham_line_drawer #(.HOR_ACTIVE_PIXELS(H), .VER_ACTIVE_PIXELS(V)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (lif)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int got_x[$];
   int got_y[$];
   int exp_x[$];
   int exp_y[$];
   int lit_x[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
   int lit_y[8] = '{0, 0, 1, 1, 2, 2, 3, 3};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference rasteriser; returns the total number of line cycles and
   // fills exp_x/exp_y with the pixels that should actually be written.
   function automatic int build_model(input int ax, input int ay, input int bx, input int by);
      int dx, dy, sx, sy, err, e2, x, y, n;
      dx  = (bx > ax) ? bx - ax : ax - bx;
      dy  = (by > ay) ? ay - by : by - ay;
      sx  = (bx >= ax) ? 1 : -1;
      sy  = (by >= ay) ? 1 : -1;
      err = dx + dy;
      x = ax;
      y = ay;
      n = 0;
      exp_x.delete();
      exp_y.delete();
      while (1) begin
         n++;
`ifdef LINE_CLIP_EN
         if (x < H && y < V) begin
            exp_x.push_back(x);
            exp_y.push_back(y);
         end
`else
         exp_x.push_back(x);
         exp_y.push_back(y);
`endif
         if (x == bx && y == by) break;
         e2 = 2 * err;
         if (e2 >= dy) begin err += dy; x += sx; end
         if (e2 <= dx) begin err += dx; y += sy; end
      end
      return n;
   endfunction

   function automatic logic pr_pattern(input int mode, input int k);
      if (mode == 0) return 1'b1;
      if (mode == 1) return (k % 3) == 0;
      return 1'($urandom_range(0, 1));
   endfunction

   // Pixel collector and stall-stability monitor, sampled mid-cycle
   logic         stall_prev = 1'b0;
   int           hold_x, hold_y;
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("stall_hold_write", 32'(lif.pixel_write), 32'd1);
            check("stall_hold_x", 32'(lif.pixel_x), 32'(hold_x));
            check("stall_hold_y", 32'(lif.pixel_y), 32'(hold_y));
         end
         if (lif.pixel_write && lif.pixel_ready) begin
            got_x.push_back(int'(lif.pixel_x));
            got_y.push_back(int'(lif.pixel_y));
         end
         stall_prev = lif.pixel_write && !lif.pixel_ready;
         hold_x = int'(lif.pixel_x);
         hold_y = int'(lif.pixel_y);
      end
   end

   task automatic scramble_inputs();
      lif.x1 = 10'($urandom);
      lif.y1 = 9'($urandom);
      lif.x2 = 10'($urandom);
      lif.y2 = 9'($urandom);
   endtask

   task automatic run_line(input string tag, input int ax, input int ay, input int bx,
                           input int by, input int mode, input bit mid_start);
      int total, cyc;
      total = build_model(ax, ay, bx, by);
      cyc = 0;
      while (!lif.ready && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, "_idle_ready"}, 32'(lif.ready), 32'd1);
      got_x.delete();
      got_y.delete();
      lif.x1 = 10'(ax);
      lif.y1 = 9'(ay);
      lif.x2 = 10'(bx);
      lif.y2 = 9'(by);
      lif.start = 1'b1;
      lif.pixel_ready = pr_pattern(mode, 0);
      @(posedge clk); #1;
      lif.start = 1'b0;
      scramble_inputs();
      check({tag, "_ready_low"}, 32'(lif.ready), 32'd0);
      cyc = 1;
      while (!lif.ready && cyc < 4 * total + 40) begin
         lif.pixel_ready = pr_pattern(mode, cyc);
         lif.start = mid_start && (cyc == 4);
         @(posedge clk); #1;
         cyc++;
      end
      lif.start = 1'b0;
      lif.pixel_ready = 1'b1;
      check({tag, "_done_ready"}, 32'(lif.ready), 32'd1);
      if (mode == 0) check({tag, "_cycles"}, 32'(cyc), 32'(total + 2));
      check({tag, "_count"}, 32'(got_x.size()), 32'(exp_x.size()));
      for (int i = 0; i < exp_x.size() && i < got_x.size(); i++) begin
         check({tag, "_pix"}, 32'((got_x[i] << 16) | got_y[i]), 32'((exp_x[i] << 16) | exp_y[i]));
      end
   endtask

   task automatic check_literal_shallow(input string tag);
      check({tag, "_lit_count"}, 32'(got_x.size()), 32'd8);
      for (int i = 0; i < 8 && i < got_x.size(); i++) begin
         check({tag, "_lit_pix"}, 32'((got_x[i] << 16) | got_y[i]), 32'((lit_x[i] << 16) | lit_y[i]));
      end
   endtask

   initial begin
      int cyc;
      lif.x1 = '0;
      lif.y1 = '0;
      lif.x2 = '0;
      lif.y2 = '0;
      lif.start = 1'b0;
      lif.pixel_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ready", 32'(lif.ready), 32'd1);
      check("reset_write", 32'(lif.pixel_write), 32'd0);
      check("reset_px", 32'(lif.pixel_x), 32'd0);
      check("reset_py", 32'(lif.pixel_y), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Degenerate single-pixel line
      run_line("degenerate", 0, 240, 0, 240, 0, 0);
      check("degenerate_lit", 32'(got_x.size() == 1 ? ((got_x[0] << 16) | got_y[0]) : -1), 32'((0 << 16) | 240));

      // Shallow positive line
      run_line("shallow", 0, 0, 7, 3, 0, 0);
      check_literal_shallow("shallow");

      // Steep negative line: y walks 10 down to 2, one per pixel
      run_line("steep", 5, 10, 3, 2, 0, 0);
      check("steep_count", 32'(got_y.size()), 32'd9);
      for (int i = 0; i < 9 && i < got_y.size(); i++) check("steep_y", 32'(got_y[i]), 32'(10 - i));
      if (got_x.size() > 0) check("steep_last", 32'((got_x[$] << 16) | got_y[$]), 32'((3 << 16) | 2));

      // Stalled write port plus ignored mid-line start
      run_line("stall", 0, 0, 7, 3, 1, 1);
      check_literal_shallow("stall");

      // Asynchronous reset mid-line
      got_x.delete();
      got_y.delete();
      lif.x1 = 10'd0;
      lif.y1 = 9'd0;
      lif.x2 = 10'd7;
      lif.y2 = 9'd3;
      lif.start = 1'b1;
      @(posedge clk); #1;
      lif.start = 1'b0;
      cyc = 0;
      while (got_x.size() < 3 && cyc < 30) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("rst_mid_count", 32'(got_x.size()), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_ready", 32'(lif.ready), 32'd1);
      check("rst_async_write", 32'(lif.pixel_write), 32'd0);
      check("rst_async_px", 32'(lif.pixel_x), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_hold_write", 32'(lif.pixel_write), 32'd0);
      check("rst_no_more_pix", 32'(got_x.size()), 32'd3);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_line("after_rst", 2, 9, 12, 1, 0, 0);

      // Line running off the right edge
      run_line("clip", 630, 0, 645, 0, 0, 0);
`ifdef LINE_CLIP_EN
      check("clip_writes", 32'(got_x.size()), 32'd10);
`else
      check("clip_writes", 32'(got_x.size()), 32'd16);
`endif

      // Random lines with random write-port behaviour
      for (int n = 0; n < 8; n++) begin
         run_line("rand", int'($urandom_range(0, H - 1)), int'($urandom_range(0, V - 1)),
                  int'($urandom_range(0, H - 1)), int'($urandom_range(0, V - 1)),
                  int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
